// File: rtl/id_ex_register.sv
// ID/EX pipeline register.
// Captures decoded control, register indices and datapath values from ID for use in EX.
// Stall holds the current contents. Flush, or an invalid ID slot, loads an all-zero bubble.
// The bubble has ALUOp=00, so downstream ALU control selects add. It also has no write or
// memory enables, so it has no architectural side effect.
module id_ex_register #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [1:0]        id_ALUOp,
    input  logic [3:0]        id_Funct,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_MemtoReg,
    input  logic              id_Branch,
    input  logic              id_ALUSrc,
    input  logic [DATA_W-1:0] id_PC,
    input  logic [DATA_W-1:0] id_ReadData1,
    input  logic [DATA_W-1:0] id_ReadData2,
    input  logic [DATA_W-1:0] id_Imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    output logic              ex_valid,
    output logic [1:0]        ex_ALUOp,
    output logic [3:0]        ex_Funct,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_MemtoReg,
    output logic              ex_Branch,
    output logic              ex_ALUSrc,
    output logic [DATA_W-1:0] ex_PC,
    output logic [DATA_W-1:0] ex_ReadData1,
    output logic [DATA_W-1:0] ex_ReadData2,
    output logic [DATA_W-1:0] ex_Imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd
);

    // One record for the whole stage.
    // Register indices travel with the control bits, so they are held and flushed together.
    typedef struct packed {
        logic              valid;
        logic [1:0]        alu_op;
        logic [3:0]        funct;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic              alu_src;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] read_data1;
        logic [DATA_W-1:0] read_data2;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
    } stage_t;

    stage_t id_stage;
    stage_t stage_d;
    stage_t stage_q;

    assign id_stage = {id_valid, id_ALUOp, id_Funct, id_RegWrite, id_MemRead, id_MemWrite,
                       id_MemtoReg, id_Branch, id_ALUSrc, id_PC, id_ReadData1, id_ReadData2,
                       id_Imm, id_rs1, id_rs2, id_rd};

    // Next-state selection: flush beats stall, stall holds, otherwise capture or bubble.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (!stall) begin
            stage_d = id_valid ? id_stage : '0;
        end
    end

    // Stage register; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign ex_valid     = stage_q.valid;
    assign ex_ALUOp     = stage_q.alu_op;
    assign ex_Funct     = stage_q.funct;
    assign ex_RegWrite  = stage_q.reg_write;
    assign ex_MemRead   = stage_q.mem_read;
    assign ex_MemWrite  = stage_q.mem_write;
    assign ex_MemtoReg  = stage_q.mem_to_reg;
    assign ex_Branch    = stage_q.branch;
    assign ex_ALUSrc    = stage_q.alu_src;
    assign ex_PC        = stage_q.pc;
    assign ex_ReadData1 = stage_q.read_data1;
    assign ex_ReadData2 = stage_q.read_data2;
    assign ex_Imm       = stage_q.imm;
    assign ex_rs1       = stage_q.rs1;
    assign ex_rs2       = stage_q.rs2;
    assign ex_rd        = stage_q.rd;

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register.
// Directed scenarios plus a randomized run, all compared against a rule-level model.
module tb_id_ex_register;
    localparam int unsigned DW = 64;

    typedef struct packed {
        logic          valid;
        logic [1:0]    alu_op;
        logic [3:0]    funct;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic          branch;
        logic          alu_src;
        logic [DW-1:0] pc;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [4:0]    rd;
    } pkt_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall = 1'b0;
    logic flush = 1'b0;
    pkt_t in_p = '0;
    pkt_t out_p;
    pkt_t exp_p = '0;
    int   errors = 0;
    int   checks = 0;

    logic          ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg;
    logic          ex_Branch, ex_ALUSrc;
    logic [1:0]    ex_ALUOp;
    logic [3:0]    ex_Funct;
    logic [DW-1:0] ex_PC, ex_ReadData1, ex_ReadData2, ex_Imm;
    logic [4:0]    ex_rs1, ex_rs2, ex_rd;

    always #5 clk = ~clk;

    id_ex_register #(.DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(in_p.valid), .id_ALUOp(in_p.alu_op), .id_Funct(in_p.funct),
        .id_RegWrite(in_p.reg_write), .id_MemRead(in_p.mem_read),
        .id_MemWrite(in_p.mem_write), .id_MemtoReg(in_p.mem_to_reg),
        .id_Branch(in_p.branch), .id_ALUSrc(in_p.alu_src), .id_PC(in_p.pc),
        .id_ReadData1(in_p.rd1), .id_ReadData2(in_p.rd2), .id_Imm(in_p.imm),
        .id_rs1(in_p.rs1), .id_rs2(in_p.rs2), .id_rd(in_p.rd),
        .ex_valid(ex_valid), .ex_ALUOp(ex_ALUOp), .ex_Funct(ex_Funct),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch), .ex_ALUSrc(ex_ALUSrc),
        .ex_PC(ex_PC), .ex_ReadData1(ex_ReadData1), .ex_ReadData2(ex_ReadData2),
        .ex_Imm(ex_Imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd)
    );

    assign out_p = {ex_valid, ex_ALUOp, ex_Funct, ex_RegWrite, ex_MemRead, ex_MemWrite,
                    ex_MemtoReg, ex_Branch, ex_ALUSrc, ex_PC, ex_ReadData1, ex_ReadData2,
                    ex_Imm, ex_rs1, ex_rs2, ex_rd};

    task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic pkt_t rand_pkt();
        pkt_t p;
        p.valid      = 1'($urandom);
        p.alu_op     = 2'($urandom);
        p.funct      = 4'($urandom);
        p.reg_write  = 1'($urandom);
        p.mem_read   = 1'($urandom);
        p.mem_write  = 1'($urandom);
        p.mem_to_reg = 1'($urandom);
        p.branch     = 1'($urandom);
        p.alu_src    = 1'($urandom);
        p.pc         = {$urandom, $urandom};
        p.rd1        = {$urandom, $urandom};
        p.rd2        = {$urandom, $urandom};
        p.imm        = {$urandom, $urandom};
        p.rs1        = 5'($urandom);
        p.rs2        = 5'($urandom);
        p.rd         = 5'($urandom);
        return p;
    endfunction

    // Advance one edge, apply the stage rules to the model, compare the whole output record.
    task automatic cycle();
        @(posedge clk);
        if (reset || flush) exp_p = '0;
        else if (!stall) exp_p = in_p.valid ? in_p : '0;
        #1;
        check("model", out_p, exp_p);
    endtask

    initial begin
        pkt_t seq [4];

        // Reset state, and inputs ignored while reset is held across an edge.
        #1;
        check("reset_init", out_p, '0);
        in_p = rand_pkt();
        in_p.valid = 1'b1;
        stall = 1'b1;
        cycle();
        check("reset_hold", out_p, '0);
        stall = 1'b0;
        reset = 1'b0;

        // Pass-through.
        in_p = '0;
        in_p.valid = 1'b1;
        in_p.alu_op = 2'b10;
        in_p.funct = 4'b1000;
        in_p.reg_write = 1'b1;
        in_p.rd = 5'd5;
        in_p.rd1 = 64'h10;
        cycle();
        check("pass_aluop", ex_ALUOp, 2'b10);
        check("pass_funct", ex_Funct, 4'b1000);
        check("pass_regwrite", ex_RegWrite, 1'b1);
        check("pass_rd", ex_rd, 5'd5);
        check("pass_rd1", ex_ReadData1, 64'h10);
        check("pass_valid", ex_valid, 1'b1);

        // Stall hold for three cycles, then capture after release.
        in_p.funct = 4'b0000;
        in_p.alu_op = 2'b10;
        cycle();
        stall = 1'b1;
        in_p.funct = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_funct", ex_Funct, 4'b0000);
        end
        stall = 1'b0;
        cycle();
        check("stall_release", ex_Funct, 4'b0111);

        // Flush with stall gives a bubble.
        in_p = '0;
        in_p.valid = 1'b1;
        in_p.mem_write = 1'b1;
        in_p.alu_op = 2'b00;
        in_p.rd = 5'd3;
        in_p.imm = 64'h8;
        cycle();
        check("sd_loaded", ex_MemWrite, 1'b1);
        in_p.alu_op = 2'b11;
        flush = 1'b1;
        stall = 1'b1;
        cycle();
        check("flush_valid", ex_valid, 1'b0);
        check("flush_memwrite", ex_MemWrite, 1'b0);
        check("flush_aluop", ex_ALUOp, 2'b00);
        check("flush_rd", ex_rd, 5'd0);
        check("flush_all", out_p, '0);
        flush = 1'b0;
        stall = 1'b0;

        // Invalid ID slot becomes a bubble.
        in_p = rand_pkt();
        in_p.valid = 1'b0;
        in_p.reg_write = 1'b1;
        in_p.rd = 5'd7;
        cycle();
        check("invalid_regwrite", ex_RegWrite, 1'b0);
        check("invalid_rd", ex_rd, 5'd0);

        // Back-to-back capture, each exactly one cycle late.
        for (int i = 0; i < 4; i++) begin
            seq[i] = rand_pkt();
            seq[i].valid = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            in_p = seq[i];
            cycle();
            check("b2b", out_p, seq[i]);
        end

        // Asynchronous reset between edges.
        in_p.reg_write = 1'b1;
        cycle();
        check("pre_reset_regwrite", ex_RegWrite, 1'b1);
        #2;
        reset = 1'b1;
        exp_p = '0;
        #1;
        check("async_regwrite", ex_RegWrite, 1'b0);
        check("async_all", out_p, '0);
        in_p = rand_pkt();
        in_p.valid = 1'b1;
        cycle();
        check("async_stay", out_p, '0);
        reset = 1'b0;
        in_p = rand_pkt();
        in_p.valid = 1'b1;
        cycle();
        check("post_reset_capture", out_p, in_p);

        // Reset mid-stall leaves nothing held.
        stall = 1'b1;
        in_p = rand_pkt();
        cycle();
        #2;
        reset = 1'b1;
        exp_p = '0;
        #1;
        check("stall_reset", out_p, '0);
        reset = 1'b0;
        cycle();
        check("stall_after_reset", out_p, '0);
        stall = 1'b0;

        // Randomized run with occasional asynchronous reset pulses.
        for (int i = 0; i < 400; i++) begin
            in_p = rand_pkt();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 6) == 0);
            cycle();
            if ($urandom_range(0, 49) == 0) begin
                #2;
                reset = 1'b1;
                exp_p = '0;
                #1;
                check("rand_async", out_p, '0);
                reset = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
